// File: rtl/md_sched_if.sv
// Multiply/divide scheduler interface: E-stage issue, D-stage hazard input, HI/LO and stall outputs.
// MD_CANCEL_EN adds the Cancel input used by the exception path.
interface md_sched_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        D_UsesMD;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Stall_MD;
`ifdef MD_CANCEL_EN
    logic        Cancel;
`endif

    modport master (
        output Start, MDOp, A, B, D_UsesMD,
        input  HI, LO, Busy, Stall_MD
`ifdef MD_CANCEL_EN
        , output Cancel
`endif
    );

    modport slave (
        input  Start, MDOp, A, B, D_UsesMD,
        output HI, LO, Busy, Stall_MD
`ifdef MD_CANCEL_EN
        , input Cancel
`endif
    );
endinterface

// File: rtl/md_sched.sv
// Fixed-latency mult/div sequencer owning HI/LO, with the D-stage stall request.
// Optional macro MD_CANCEL_EN: Cancel aborts a running op or suppresses an issue.
module md_sched #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic      CLK,
    input  logic      Reset,
    md_sched_if.slave md
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [1:0]       op_q, op_d;
    logic             cancel, issue, done;

`ifdef MD_CANCEL_EN
    assign cancel = md.Cancel;
`else
    assign cancel = 1'b0;
`endif

    assign issue = (state_q == IDLE) && md.Start && !md.MDOp[2] && !cancel;
    assign done  = (state_q == RUN) && !cancel && (cnt_q == CNT_W'(1));

    // Results come only from the latched operands.
    logic signed [63:0] a_sx, b_sx;
    logic [63:0]        prod_s, prod_u;
    logic               div_zero, div_ovf;
    logic [31:0]        dsor_s, dsor_u, quo_s, rem_s, quo_u, rem_u;

    always_comb begin
        a_sx     = {{32{a_q[31]}}, a_q};
        b_sx     = {{32{b_q[31]}}, b_q};
        prod_s   = a_sx * b_sx;
        prod_u   = {32'd0, a_q} * {32'd0, b_q};
        div_zero = (b_q == 32'd0);
        div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        // Substitute a safe divisor so the divider never sees /0 or INT_MIN/-1.
        dsor_s   = (div_zero || div_ovf) ? 32'd1 : b_q;
        dsor_u   = div_zero ? 32'd1 : b_q;
        quo_s    = $signed(a_q) / $signed(dsor_s);
        rem_s    = $signed(a_q) % $signed(dsor_s);
        if (div_ovf) begin
            quo_s = 32'h8000_0000;
            rem_s = 32'd0;
        end
        quo_u    = a_q / dsor_u;
        rem_u    = a_q % dsor_u;
    end

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = RUN;
            RUN:     if (cancel || done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        md.Busy     = (state_q == RUN);
        md.Stall_MD = md.D_UsesMD & ((state_q == RUN) | (md.Start & !md.MDOp[2]));
        md.HI       = hi_q;
        md.LO       = lo_q;
    end

    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        op_d = op_q;
        cnt_d = cnt_q;
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == IDLE) begin
            if (issue) begin
                a_d   = md.A;
                b_d   = md.B;
                op_d  = md.MDOp[1:0];
                cnt_d = md.MDOp[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            end else if (md.Start && !cancel && md.MDOp == 3'd4) begin
                hi_d = md.A;
            end else if (md.Start && !cancel && md.MDOp == 3'd5) begin
                lo_d = md.A;
            end
        end else if (cancel) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (done) begin
                case (op_q)
                    2'd0: {hi_d, lo_d} = prod_s;
                    2'd1: {hi_d, lo_d} = prod_u;
                    2'd2: if (!div_zero) begin hi_d = rem_s; lo_d = quo_s; end
                    default: if (!div_zero) begin hi_d = rem_u; lo_d = quo_u; end
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: arithmetic model of HI/LO/Busy/Stall checked every cycle,
// plus literal expectations from hand-computed vectors.
module tb_md_sched;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    md_sched_if bus();
    md_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .CLK(clk), .Reset(rst), .md(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // {HI,LO} for an op, from plain 64-bit arithmetic; cur is kept for divide by zero.
    function automatic logic [63:0] md_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] cur);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd0: return sa * sb;
            2'd1: return ua * ub;
            2'd2: begin
                if (b == 0) return cur;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return cur;
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_left = 0;
    bit          m_init = 1'b0;
    logic        m_cancel;

`ifdef MD_CANCEL_EN
    assign m_cancel = bus.Cancel;
`else
    assign m_cancel = 1'b0;
`endif

    always @(posedge clk) begin
        m_init = 1'b1;
        if (rst) begin
            m_hi = 0; m_lo = 0; m_left = 0;
        end else if (m_left > 0) begin
            if (m_cancel) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0) {m_hi, m_lo} = m_pend;
            end
        end else if (bus.Start && !m_cancel) begin
            if (bus.MDOp <= 3) begin
                m_pend = md_result(bus.MDOp[1:0], bus.A, bus.B, {m_hi, m_lo});
                m_left = (bus.MDOp >= 2) ? DIV_LAT : MUL_LAT;
            end else if (bus.MDOp == 4) m_hi = bus.A;
            else if (bus.MDOp == 5) m_lo = bus.A;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_hi", bus.HI, m_hi);
            chk("model_lo", bus.LO, m_lo);
            chk("model_busy", {31'd0, bus.Busy}, {31'd0, m_left > 0});
            chk("model_stall", {31'd0, bus.Stall_MD},
                {31'd0, bus.D_UsesMD && (m_left > 0 || (bus.Start && bus.MDOp <= 3))});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
        cyc();
        bus.Start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.Busy && n < 100) begin
            cyc();
            n++;
        end
    endtask

    int n;

    initial begin
        rst = 1'b1;
        bus.Start = 1'b0; bus.MDOp = 3'd7; bus.A = '0; bus.B = '0; bus.D_UsesMD = 1'b0;
`ifdef MD_CANCEL_EN
        bus.Cancel = 1'b0;
`endif
        cyc(); cyc();
        chk("rst_hi", bus.HI, 32'h0);
        chk("rst_lo", bus.LO, 32'h0);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        rst = 1'b0;

        issue(3'd0, 32'd3, 32'hFFFF_FFFE);
        wait_idle(n);
        chk("mult_lat", n, MUL_LAT);
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFFA);

        issue(3'd3, 32'hFFFF_FFFF, 32'h10);
        wait_idle(n);
        chk("divu_lat", n, DIV_LAT);
        chk("divu_lo", bus.LO, 32'h0FFF_FFFF);
        chk("divu_hi", bus.HI, 32'hF);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_lo", bus.LO, 32'hFFFF_FFFD);
        chk("div_hi", bus.HI, 32'hFFFF_FFFF);

        issue(3'd4, 32'h1234, 32'd0);
        chk("mthi_busy", {31'd0, bus.Busy}, 32'd0);
        issue(3'd5, 32'h5678, 32'd0);
        chk("mtlo_busy", {31'd0, bus.Busy}, 32'd0);
        chk("mthi_hi", bus.HI, 32'h1234);
        chk("mtlo_lo", bus.LO, 32'h5678);

        // mflo sitting in D while a mult issues
        bus.D_UsesMD = 1'b1;
        bus.Start = 1'b1; bus.MDOp = 3'd0; bus.A = 32'd7; bus.B = 32'd6;
        #1;
        chk("stall_issue", {31'd0, bus.Stall_MD}, 32'd1);
        cyc();
        bus.Start = 1'b0;
        n = 0;
        while (bus.Busy && n < 100) begin
            chk("stall_busy", {31'd0, bus.Stall_MD}, 32'd1);
            cyc();
            n++;
        end
        chk("stall_lat", n, MUL_LAT);
        chk("stall_release", {31'd0, bus.Stall_MD}, 32'd0);
        chk("stall_lo", bus.LO, 32'd42);
        bus.D_UsesMD = 1'b0;

        issue(3'd1, 32'h10000, 32'h10000);
        wait_idle(n);
        chk("multu_hi", bus.HI, 32'h1);
        chk("multu_lo", bus.LO, 32'h0);

        issue(3'd4, 32'hAA, 32'd0);
        issue(3'd5, 32'hBB, 32'd0);
        issue(3'd2, 32'd5, 32'd0);
        cyc(); cyc(); cyc();
        issue(3'd1, 32'd2, 32'd2);
        wait_idle(n);
        chk("divz_lat", n + 4, DIV_LAT);
        chk("divz_hi", bus.HI, 32'hAA);
        chk("divz_lo", bus.LO, 32'hBB);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("ovf_lo", bus.LO, 32'h8000_0000);
        chk("ovf_hi", bus.HI, 32'h0);

        // Reset in the third busy cycle of a div
        bus.D_UsesMD = 1'b1;
        issue(3'd2, 32'd100, 32'd7);
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstrun_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rstrun_hi", bus.HI, 32'h0);
        chk("rstrun_lo", bus.LO, 32'h0);
        chk("rstrun_stall", {31'd0, bus.Stall_MD}, 32'd0);
        bus.Start = 1'b1; bus.MDOp = 3'd2;
        #1;
        chk("rstrun_stall_start", {31'd0, bus.Stall_MD}, 32'd1);
        bus.Start = 1'b0;
        bus.D_UsesMD = 1'b0;
        #1;

`ifdef MD_CANCEL_EN
        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        issue(3'd0, 32'd3, 32'd3);
        cyc();
        bus.Cancel = 1'b1;
        cyc();
        bus.Cancel = 1'b0;
        chk("cancel_busy", {31'd0, bus.Busy}, 32'd0);
        chk("cancel_hi", bus.HI, 32'h11);
        chk("cancel_lo", bus.LO, 32'h22);
        bus.Cancel = 1'b1;
        issue(3'd4, 32'h99, 32'd0);
        bus.Cancel = 1'b0;
        chk("cancel_mthi", bus.HI, 32'h11);
`endif

        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
